// File: rtl/proc_pkg.sv
// Shared constants and types for the program loader and its instruction RAM.
package proc_pkg;

  localparam int unsigned INSTR_W = 10;
  localparam int unsigned ADDR_W  = 8;

  // All-zero instruction: no register write, no memory write, no branch.
  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN
  } loader_state_t;

endpackage

// File: rtl/imem.sv
// Instruction RAM with one synchronous write port and one asynchronous read port.
module imem
  import proc_pkg::*;
#(
  parameter int unsigned IW = INSTR_W,
  parameter int unsigned AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [IW-1:0] mem [DEPTH];

  // Contents are deliberately not reset so a reload only overwrites what it supplies.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: deserialises a bit stream into instruction RAM while holding
// the processor in reset, then serves fetches combinationally.
module prog_loader
  import proc_pkg::*;
#(
  parameter int unsigned IW = INSTR_W,
  parameter int unsigned AW = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_end,
  input  logic          sdata_valid,
  input  logic          sdata,
  input  logic [AW-1:0] adr,
  output logic [IW-1:0] instruct,
  output logic          cpu_reset,
  output logic          loading,
  output logic [AW:0]   words_loaded,
  output logic          err_partial,
  output logic          err_overflow
);

  localparam int unsigned BCW   = $clog2(IW);
  localparam int unsigned WLW   = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;

  loader_state_t  state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [IW-2:0]  shift_q, shift_d;
  logic [WLW-1:0] words_d;
  logic           err_p_d, err_o_d;
  logic           we_c;
  logic [IW-1:0]  wdata_c;
  logic [IW-1:0]  rdata_c;

  // Next-state, datapath and RAM write control.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wptr_d    = wptr_q;
    shift_d   = shift_q;
    words_d   = words_loaded;
    err_p_d   = err_partial;
    err_o_d   = err_overflow;
    we_c      = 1'b0;
    wdata_c   = {shift_q, sdata};

    case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          wptr_d    = '0;
          words_d   = '0;
          err_p_d   = 1'b0;
          err_o_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_start) begin
          bit_cnt_d = '0;
          wptr_d    = '0;
          words_d   = '0;
          err_p_d   = 1'b0;
          err_o_d   = 1'b0;
        end else begin
          // The incoming bit is accepted before load_end is judged.
          if (sdata_valid) begin
            shift_d = wdata_c[IW-2:0];
            if (bit_cnt_q == BCW'(IW - 1)) begin
              bit_cnt_d = '0;
              if (words_loaded == WLW'(DEPTH)) begin
                err_o_d = 1'b1;
              end else begin
                we_c    = 1'b1;
                wptr_d  = wptr_q + AW'(1);
                words_d = words_loaded + WLW'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
          if (load_end) begin
            if (bit_cnt_d != '0) begin
              err_p_d = 1'b1;
            end
            bit_cnt_d = '0;
            state_d   = RELEASE;
          end
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      wptr_q       <= '0;
      shift_q      <= '0;
      words_loaded <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      cpu_reset    <= 1'b1;
      loading      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      wptr_q       <= wptr_d;
      shift_q      <= shift_d;
      words_loaded <= words_d;
      err_partial  <= err_p_d;
      err_overflow <= err_o_d;
      cpu_reset    <= (state_d != RUN);
      loading      <= (state_d == LOAD);
    end
  end

  imem #(
    .IW(IW),
    .AW(AW)
  ) u_imem (
    .clk  (clk),
    .we   (we_c),
    .waddr(wptr_q),
    .wdata(wdata_c),
    .raddr(adr),
    .rdata(rdata_c)
  );

  // Memory is only visible once the load has been closed out.
  assign instruct = (state_q == RELEASE || state_q == RUN) ? rdata_c : IW'(NOP);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a default-size instance and a 4-word instance
// share one stimulus stream; expectations are queued and checked by a monitor.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start, load_end, sdata_valid, sdata;
  logic [7:0] adr_a;
  logic [1:0] adr_b;

  logic [9:0] instruct_a, instruct_b;
  logic       cpu_reset_a, cpu_reset_b, loading_a, loading_b;
  logic [8:0] words_a;
  logic [2:0] words_b;
  logic       errp_a, errp_b, erro_a, erro_b;

  always #5 clk = ~clk;

  prog_loader #(.IW(10), .AW(8)) dut_a (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .sdata_valid(sdata_valid), .sdata(sdata), .adr(adr_a), .instruct(instruct_a),
    .cpu_reset(cpu_reset_a), .loading(loading_a), .words_loaded(words_a),
    .err_partial(errp_a), .err_overflow(erro_a)
  );

  prog_loader #(.IW(10), .AW(2)) dut_b (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .sdata_valid(sdata_valid), .sdata(sdata), .adr(adr_b), .instruct(instruct_b),
    .cpu_reset(cpu_reset_b), .loading(loading_b), .words_loaded(words_b),
    .err_partial(errp_b), .err_overflow(erro_b)
  );

  localparam int S_INSTR = 0, S_CPURST = 1, S_LOADING = 2, S_WORDS = 3, S_ERRP = 4, S_ERRO = 5;

  typedef struct {
    string       name;
    int          inst;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] actual(input int inst, input int sel);
    if (inst == 0) begin
      case (sel)
        S_INSTR:   return 32'(instruct_a);
        S_CPURST:  return 32'(cpu_reset_a);
        S_LOADING: return 32'(loading_a);
        S_WORDS:   return 32'(words_a);
        S_ERRP:    return 32'(errp_a);
        default:   return 32'(erro_a);
      endcase
    end else begin
      case (sel)
        S_INSTR:   return 32'(instruct_b);
        S_CPURST:  return 32'(cpu_reset_b);
        S_LOADING: return 32'(loading_b);
        S_WORDS:   return 32'(words_b);
        S_ERRP:    return 32'(errp_b);
        default:   return 32'(erro_b);
      endcase
    end
  endfunction

  // Monitor: drains every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = q.pop_front();
      act = actual(c.inst, c.sel);
      n_cmp++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s (dut_%s): got 0x%0h, required 0x%0h",
                 c.name, (c.inst == 0) ? "a" : "b", act, c.exp);
      end
    end
  end

  task automatic chk(input string nm, input int inst, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.inst = inst;
    c.sel  = sel;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic chk2(input string nm, input int sel, input logic [31:0] exp);
    chk(nm, 0, sel, exp);
    chk(nm, 1, sel, exp);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail += q.size();
      $display("FAIL monitor_timeout: %0d checks pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adr(input int a);
    adr_a = 8'(a);
    adr_b = 2'(a);
  endtask

  task automatic probe(input string nm, input int a, input logic [9:0] e, input bit both);
    set_adr(a);
    if (both) chk2(nm, S_INSTR, 32'(e));
    else      chk(nm, 0, S_INSTR, 32'(e));
    sync();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      sdata_valid = 1'b1;
      sdata       = v[i];
      tick();
    end
    sdata_valid = 1'b0;
    sdata       = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sdata_valid = 1'b1;
    sdata       = b;
    tick();
    sdata_valid = 1'b0;
    sdata       = 1'b0;
  endtask

  initial begin
    logic [9:0] w;
    reset = 1'b0; load_start = 1'b0; load_end = 1'b0;
    sdata_valid = 1'b0; sdata = 1'b0;
    set_adr(0);
    tick();
    tick();

    // Reset values
    chk2("rst_cpu_reset", S_CPURST, 32'd1);
    chk2("rst_instruct", S_INSTR, 32'd0);
    chk2("rst_loading", S_LOADING, 32'd0);
    chk2("rst_words", S_WORDS, 32'd0);
    chk2("rst_err_partial", S_ERRP, 32'd0);
    chk2("rst_err_overflow", S_ERRO, 32'd0);
    sync();
    reset = 1'b1;
    tick();
    chk2("idle_cpu_reset", S_CPURST, 32'd1);
    sync();

    // Three-word load
    pulse_start();
    chk2("load_loading", S_LOADING, 32'd1);
    chk2("load_cpu_reset", S_CPURST, 32'd1);
    chk2("load_instr_nop", S_INSTR, 32'd0);
    sync();
    send_word(10'h2A5);
    send_word(10'h3FF);
    send_word(10'h001);
    pulse_end();
    chk2("rel_words", S_WORDS, 32'd3);
    chk2("rel_err_partial", S_ERRP, 32'd0);
    chk2("rel_err_overflow", S_ERRO, 32'd0);
    chk2("rel_cpu_reset", S_CPURST, 32'd1);
    chk2("rel_loading", S_LOADING, 32'd0);
    probe("rel_instr_adr0", 0, 10'h2A5, 1'b1);
    tick();
    chk2("run_cpu_reset", S_CPURST, 32'd0);
    probe("run_adr0", 0, 10'h2A5, 1'b1);
    probe("run_adr1", 1, 10'h3FF, 1'b1);
    probe("run_adr2", 2, 10'h001, 1'b1);

    // Partial trailing word
    pulse_start();
    chk2("reload_cpu_reset", S_CPURST, 32'd1);
    chk2("reload_instr_nop", S_INSTR, 32'd0);
    sync();
    send_word(10'h155);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_end();
    chk2("partial_words", S_WORDS, 32'd1);
    chk2("partial_err", S_ERRP, 32'd1);
    sync();
    tick();
    probe("partial_adr0", 0, 10'h155, 1'b1);
    probe("partial_adr1_kept", 1, 10'h3FF, 1'b1);

    // Overflow on the 4-word instance
    pulse_start();
    chk2("ovf_errp_cleared", S_ERRP, 32'd0);
    chk2("ovf_cpu_reset", S_CPURST, 32'd1);
    sync();
    send_word(10'h011);
    send_word(10'h022);
    send_word(10'h033);
    send_word(10'h044);
    send_word(10'h0AB);
    chk("ovf_words_small", 1, S_WORDS, 32'd4);
    chk("ovf_flag_small", 1, S_ERRO, 32'd1);
    chk("ovf_words_big", 0, S_WORDS, 32'd5);
    chk("ovf_flag_big", 0, S_ERRO, 32'd0);
    sync();
    pulse_end();
    tick();
    chk2("ovf_run_cpu_reset", S_CPURST, 32'd0);
    probe("ovf_adr0_kept", 0, 10'h011, 1'b1);
    probe("ovf_adr3", 3, 10'h044, 1'b1);
    probe("ovf_adr4_big", 4, 10'h0AB, 1'b0);

    // Reload from RUN; last bit coincides with load_end
    pulse_start();
    chk("reload_erro_cleared", 1, S_ERRO, 32'd0);
    chk2("reload2_instr_nop", S_INSTR, 32'd0);
    chk2("reload2_words_cleared", S_WORDS, 32'd0);
    sync();
    w = 10'h123;
    for (int i = 9; i >= 1; i--) send_bit(w[i]);
    sdata_valid = 1'b1;
    sdata       = w[0];
    load_end    = 1'b1;
    tick();
    sdata_valid = 1'b0;
    sdata       = 1'b0;
    load_end    = 1'b0;
    chk2("endbit_words", S_WORDS, 32'd1);
    chk2("endbit_err_partial", S_ERRP, 32'd0);
    sync();
    tick();
    probe("endbit_adr0", 0, 10'h123, 1'b1);

    // Async reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b0;
    chk2("midrst_cpu_reset", S_CPURST, 32'd1);
    chk2("midrst_loading", S_LOADING, 32'd0);
    chk2("midrst_words", S_WORDS, 32'd0);
    sync();
    tick();
    reset = 1'b1;
    tick();
    chk2("postrst_loading", S_LOADING, 32'd0);
    chk2("postrst_instr", S_INSTR, 32'd0);
    sync();
    pulse_start();
    send_word(10'h2A5);
    send_word(10'h3FF);
    send_word(10'h001);
    pulse_end();
    chk2("postrst_words", S_WORDS, 32'd3);
    chk2("postrst_err_partial", S_ERRP, 32'd0);
    sync();
    tick();
    probe("postrst_adr0", 0, 10'h2A5, 1'b1);
    probe("postrst_adr1", 1, 10'h3FF, 1'b1);
    probe("postrst_adr2", 2, 10'h001, 1'b1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
